mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter: STALL_CNT_W, default 16, width of the saturating contention counter.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 i_mem_read  input  1  I-cache line read request, held until i_mem_resp.
REQ-005 i_mem_address  input  lc3b_word  I-cache line address.
REQ-006 i_mem_resp  output  1  I-cache transaction complete, one-cycle pulse.
REQ-007 i_mem_rdata  output  lc3b_cacheline  I-cache read data, valid with i_mem_resp.
REQ-008 d_mem_read, d_mem_write  input  1 each  D-cache requests, held until d_mem_resp.
REQ-009 d_mem_address  input  lc3b_word  D-cache line address.
REQ-010 d_mem_wdata  input  lc3b_cacheline  D-cache writeback line.
REQ-011 d_mem_resp  output  1  D-cache transaction complete, one-cycle pulse.
REQ-012 d_mem_rdata  output  lc3b_cacheline  D-cache read data, valid with d_mem_resp.
REQ-013 buf_mem_read, buf_mem_write  output  1 each  requests to the eviction buffer.
REQ-014 buf_mem_address  output  lc3b_word; buf_mem_wdata  output  lc3b_cacheline  forwarded address/data.
REQ-015 buf_mem_resp  input  1; buf_mem_rdata  input  lc3b_cacheline  eviction buffer response.
REQ-016 stall_count  output  STALL_CNT_W  cycles any requester waited while the other held the grant.

Function
REQ-017 FSM states SHALL be IDLE, SERVE_I, SERVE_D.
REQ-018 IDLE: buf_mem_read/write = 0; a pending request moves the FSM to SERVE_x on the next edge (grant latency 1 cycle).
REQ-019 SERVE_x: buf_mem_* SHALL combinationally mirror the granted requester's read/write/address/wdata; the other requester's resp stays 0.
REQ-020 buf_mem_resp in SERVE_x SHALL drive the granted x_mem_resp in the same cycle, with x_mem_rdata = buf_mem_rdata; FSM returns to IDLE on the next edge.
REQ-021 One mandatory IDLE cycle SHALL follow every completion, so the requester can drop its request before re-arbitration.
REQ-022 i_mem_rdata and d_mem_rdata SHALL be driven from buf_mem_rdata at all times; only resp is gated.
REQ-023 d_mem_read and d_mem_write both asserted: write wins, and buf_mem_read SHALL be 0.
REQ-024 Grant SHALL never change while in SERVE_x, regardless of new requests.
REQ-025 stall_count increments by 1 per cycle in SERVE_x while the non-granted requester asserts a request; it SHALL saturate at all-ones, with no wrap.
REQ-026 A request dropped before its grant SHALL be ignored; no transaction is issued.

Reset
REQ-027 rst_n low SHALL asynchronously force IDLE, last-grant = I, stall_count = 0, and all buf_mem_* requests and resp outputs to 0.
REQ-028 Reset mid-transaction abandons it; no resp is generated for it after reset release.

Configuration
REQ-029 ARB_RR_EN defined: round-robin; when both requesters are pending in IDLE, grant goes to the one not granted last.
REQ-030 ARB_RR_EN undefined: fixed priority, D over I; the last-grant register is not built.

Structure
REQ-031 The arb_state_t enum SHALL live in lc3b_types, alongside the existing lc3b_word and lc3b_cacheline.
REQ-032 Single module, no sub-modules; FSM and counter are inline.

Verification
REQ-033 I read only, address 0x1230, buf_mem_resp after 3 cycles -> buf_mem_read high from cycle 1; i_mem_resp same cycle as buf_mem_resp; IDLE one cycle later.
REQ-034 D write, address 0x4400, wdata pattern 0xA5.. -> buf_mem_write = 1, buf_mem_wdata matches; d_mem_resp pulses once.
REQ-035 Both requesters pending from reset, with ARB_RR_EN -> D, I, D, I; without it -> D served repeatedly while held; stall_count counts I wait cycles.
REQ-036 STALL_CNT_W = 4, I starved for 20 cycles -> stall_count stops at 15.
REQ-037 rst_n pulsed low mid SERVE_D -> outputs 0 immediately; no d_mem_resp after release; state IDLE.
REQ-038 d_mem_read and d_mem_write asserted together -> only buf_mem_write is asserted.

Source files
------------

// File: rtl/lc3b_types.sv
// rtl/lc3b_types.sv - shared LC-3b word/cacheline types and arbiter state encoding
package lc3b_types;

    typedef logic [15:0]  lc3b_word;
    typedef logic [127:0] lc3b_cacheline;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SERVE_I = 2'd1,
        SERVE_D = 2'd2
    } arb_state_t;

endpackage

// File: rtl/mem_arbiter_if.sv
// rtl/mem_arbiter_if.sv - I-cache/D-cache request bus and eviction-buffer bus seen by the arbiter
interface mem_arbiter_if;
    import lc3b_types::*;

    logic          i_mem_read;
    lc3b_word      i_mem_address;
    logic          i_mem_resp;
    lc3b_cacheline i_mem_rdata;

    logic          d_mem_read;
    logic          d_mem_write;
    lc3b_word      d_mem_address;
    lc3b_cacheline d_mem_wdata;
    logic          d_mem_resp;
    lc3b_cacheline d_mem_rdata;

    logic          buf_mem_read;
    logic          buf_mem_write;
    lc3b_word      buf_mem_address;
    lc3b_cacheline buf_mem_wdata;
    logic          buf_mem_resp;
    lc3b_cacheline buf_mem_rdata;

    // Caches and eviction buffer together, as seen from outside the arbiter.
    modport master (
        output i_mem_read, i_mem_address,
        output d_mem_read, d_mem_write, d_mem_address, d_mem_wdata,
        output buf_mem_resp, buf_mem_rdata,
        input  i_mem_resp, i_mem_rdata, d_mem_resp, d_mem_rdata,
        input  buf_mem_read, buf_mem_write, buf_mem_address, buf_mem_wdata
    );

    modport slave (
        input  i_mem_read, i_mem_address,
        input  d_mem_read, d_mem_write, d_mem_address, d_mem_wdata,
        input  buf_mem_resp, buf_mem_rdata,
        output i_mem_resp, i_mem_rdata, d_mem_resp, d_mem_rdata,
        output buf_mem_read, buf_mem_write, buf_mem_address, buf_mem_wdata
    );

endinterface

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - I/D cache arbiter onto the eviction buffer; ARB_RR_EN selects round-robin over fixed D>I priority
module mem_arbiter
    import lc3b_types::*;
#(
    parameter int STALL_CNT_W = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    mem_arbiter_if.slave           bus,
    output logic [STALL_CNT_W-1:0] stall_count
);

    arb_state_t state;
    logic       i_pend;
    logic       d_pend;
    logic       grant_d;
    logic       other_waiting;

    assign i_pend = bus.i_mem_read;
    assign d_pend = bus.d_mem_read | bus.d_mem_write;

`ifdef ARB_RR_EN
    logic last_d;

    // On contention the requester not served last wins; otherwise whoever asks.
    assign grant_d = d_pend & (~i_pend | ~last_d);
`else
    assign grant_d = d_pend;
`endif

    assign other_waiting = ((state == SERVE_I) & d_pend) |
                           ((state == SERVE_D) & i_pend);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            stall_count <= '0;
`ifdef ARB_RR_EN
            last_d      <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (grant_d) begin
                        state  <= SERVE_D;
`ifdef ARB_RR_EN
                        last_d <= 1'b1;
`endif
                    end else if (i_pend) begin
                        state  <= SERVE_I;
`ifdef ARB_RR_EN
                        last_d <= 1'b0;
`endif
                    end
                end
                SERVE_I, SERVE_D: begin
                    // Completion always returns through IDLE so the requester can drop its request.
                    if (bus.buf_mem_resp)
                        state <= IDLE;
                end
                default: state <= IDLE;
            endcase

            if (other_waiting && (stall_count != '1))
                stall_count <= stall_count + 1'b1;
        end
    end

    always_comb begin
        bus.buf_mem_read    = 1'b0;
        bus.buf_mem_write   = 1'b0;
        bus.buf_mem_address = '0;
        bus.buf_mem_wdata   = '0;
        bus.i_mem_resp      = 1'b0;
        bus.d_mem_resp      = 1'b0;
        case (state)
            SERVE_I: begin
                bus.buf_mem_read    = bus.i_mem_read;
                bus.buf_mem_address = bus.i_mem_address;
                bus.i_mem_resp      = bus.buf_mem_resp;
            end
            SERVE_D: begin
                // A simultaneous read+write from the D-cache is treated as a write.
                bus.buf_mem_write   = bus.d_mem_write;
                bus.buf_mem_read    = bus.d_mem_read & ~bus.d_mem_write;
                bus.buf_mem_address = bus.d_mem_address;
                bus.buf_mem_wdata   = bus.d_mem_wdata;
                bus.d_mem_resp      = bus.buf_mem_resp;
            end
            default: ;
        endcase
    end

    assign bus.i_mem_rdata = bus.buf_mem_rdata;
    assign bus.d_mem_rdata = bus.buf_mem_rdata;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - directed self-checking bench for mem_arbiter
module tb_mem_arbiter;
    import lc3b_types::*;

    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [CW-1:0] stall_count;
    int            checks = 0;
    int            errors = 0;

    mem_arbiter_if bus();

    mem_arbiter #(.STALL_CNT_W(CW)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .bus         (bus),
        .stall_count (stall_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        bus.i_mem_read    = 1'b0;
        bus.i_mem_address = '0;
        bus.d_mem_read    = 1'b0;
        bus.d_mem_write   = 1'b0;
        bus.d_mem_address = '0;
        bus.d_mem_wdata   = '0;
        bus.buf_mem_resp  = 1'b0;
        bus.buf_mem_rdata = '0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        lc3b_cacheline rd_pat;
        lc3b_cacheline wd_pat;
        int            pulses;
        int            activity;
        bit            exp_d;

        rd_pat = 128'hDEAD_BEEF_0123_4567_89AB_CDEF_0F1E_2D3C;
        wd_pat = {16{8'hA5}};
        clear_inputs();

        // Reset state
        @(negedge clk);
        check("rst_state", 128'(dut.state), 128'(IDLE));
        check("rst_buf_rd", 128'(bus.buf_mem_read), 128'(1'b0));
        check("rst_buf_wr", 128'(bus.buf_mem_write), 128'(1'b0));
        check("rst_i_resp", 128'(bus.i_mem_resp), 128'(1'b0));
        check("rst_d_resp", 128'(bus.d_mem_resp), 128'(1'b0));
        check("rst_stall", 128'(stall_count), 128'(4'd0));
        tick();
        rst_n = 1'b1;

        // I read 0x1230, buffer answers on the third serve cycle
        bus.i_mem_read    = 1'b1;
        bus.i_mem_address = 16'h1230;
        @(negedge clk);
        check("t1_idle_state", 128'(dut.state), 128'(IDLE));
        check("t1_idle_rd", 128'(bus.buf_mem_read), 128'(1'b0));
        tick();
        @(negedge clk);
        check("t1_c1_state", 128'(dut.state), 128'(SERVE_I));
        check("t1_c1_rd", 128'(bus.buf_mem_read), 128'(1'b1));
        check("t1_c1_wr", 128'(bus.buf_mem_write), 128'(1'b0));
        check("t1_c1_addr", 128'(bus.buf_mem_address), 128'(16'h1230));
        check("t1_c1_iresp", 128'(bus.i_mem_resp), 128'(1'b0));
        tick();
        @(negedge clk);
        check("t1_c2_rd", 128'(bus.buf_mem_read), 128'(1'b1));
        check("t1_c2_iresp", 128'(bus.i_mem_resp), 128'(1'b0));
        tick();
        bus.buf_mem_resp  = 1'b1;
        bus.buf_mem_rdata = rd_pat;
        @(negedge clk);
        check("t1_c3_iresp", 128'(bus.i_mem_resp), 128'(1'b1));
        check("t1_c3_irdata", bus.i_mem_rdata, rd_pat);
        check("t1_c3_dresp", 128'(bus.d_mem_resp), 128'(1'b0));
        tick();
        bus.buf_mem_resp = 1'b0;
        bus.i_mem_read   = 1'b0;
        @(negedge clk);
        check("t1_done_state", 128'(dut.state), 128'(IDLE));
        check("t1_done_iresp", 128'(bus.i_mem_resp), 128'(1'b0));
        check("t1_done_rd", 128'(bus.buf_mem_read), 128'(1'b0));

        // D write 0x4400 with 0xA5 pattern
        tick();
        bus.d_mem_write   = 1'b1;
        bus.d_mem_address = 16'h4400;
        bus.d_mem_wdata   = wd_pat;
        @(negedge clk);
        check("t2_idle_wr", 128'(bus.buf_mem_write), 128'(1'b0));
        tick();
        @(negedge clk);
        check("t2_state", 128'(dut.state), 128'(SERVE_D));
        check("t2_wr", 128'(bus.buf_mem_write), 128'(1'b1));
        check("t2_rd", 128'(bus.buf_mem_read), 128'(1'b0));
        check("t2_addr", 128'(bus.buf_mem_address), 128'(16'h4400));
        check("t2_wdata", bus.buf_mem_wdata, wd_pat);
        tick();
        bus.buf_mem_resp = 1'b1;
        @(negedge clk);
        check("t2_dresp", 128'(bus.d_mem_resp), 128'(1'b1));
        check("t2_iresp", 128'(bus.i_mem_resp), 128'(1'b0));
        tick();
        bus.buf_mem_resp = 1'b0;
        bus.d_mem_write  = 1'b0;
        pulses = 0;
        repeat (3) begin
            @(negedge clk);
            if (bus.d_mem_resp) pulses++;
            tick();
        end
        check("t2_extra_pulses", 128'(pulses), 128'(0));

        // D read and write together: write wins
        bus.d_mem_read    = 1'b1;
        bus.d_mem_write   = 1'b1;
        bus.d_mem_address = 16'h5500;
        tick();
        @(negedge clk);
        check("t3_wr", 128'(bus.buf_mem_write), 128'(1'b1));
        check("t3_rd", 128'(bus.buf_mem_read), 128'(1'b0));
        tick();
        bus.buf_mem_resp = 1'b1;
        @(negedge clk);
        check("t3_dresp", 128'(bus.d_mem_resp), 128'(1'b1));
        tick();
        bus.buf_mem_resp = 1'b0;
        bus.d_mem_read   = 1'b0;
        bus.d_mem_write  = 1'b0;

        // I request dropped while D holds the grant is never issued
        bus.d_mem_read    = 1'b1;
        bus.d_mem_address = 16'h6600;
        tick();
        bus.i_mem_read    = 1'b1;
        bus.i_mem_address = 16'h1000;
        @(negedge clk);
        check("t4_grant_addr", 128'(bus.buf_mem_address), 128'(16'h6600));
        tick();
        bus.i_mem_read = 1'b0;
        tick();
        bus.buf_mem_resp = 1'b1;
        @(negedge clk);
        check("t4_dresp", 128'(bus.d_mem_resp), 128'(1'b1));
        tick();
        bus.buf_mem_resp = 1'b0;
        bus.d_mem_read   = 1'b0;
        activity = 0;
        repeat (3) begin
            @(negedge clk);
            if (bus.buf_mem_read || bus.buf_mem_write || bus.i_mem_resp) activity++;
            tick();
        end
        check("t4_no_issue", 128'(activity), 128'(0));
        check("t4_stall", 128'(stall_count), 128'(4'd1));

        // Both pending from reset
        rst_n = 1'b0;
        clear_inputs();
        tick();
        bus.d_mem_read    = 1'b1;
        bus.d_mem_address = 16'hD000;
        bus.i_mem_read    = 1'b1;
        bus.i_mem_address = 16'h1000;
        tick();
        rst_n = 1'b1;
        for (int k = 0; k < 4; k++) begin
`ifdef ARB_RR_EN
            exp_d = ((k % 2) == 0);
`else
            exp_d = 1'b1;
`endif
            tick();
            @(negedge clk);
            check($sformatf("t5_grant%0d", k), 128'(bus.buf_mem_address),
                  128'(exp_d ? 16'hD000 : 16'h1000));
            tick();
            bus.buf_mem_resp = 1'b1;
            @(negedge clk);
            check($sformatf("t5_dresp%0d", k), 128'(bus.d_mem_resp), 128'(exp_d));
            check($sformatf("t5_iresp%0d", k), 128'(bus.i_mem_resp), 128'(!exp_d));
            tick();
            bus.buf_mem_resp = 1'b0;
            @(negedge clk);
            check($sformatf("t5_idle%0d", k), 128'(dut.state), 128'(IDLE));
        end
        check("t5_stall", 128'(stall_count), 128'(4'd8));

        // I starved behind a long D transaction: counter saturates
        rst_n = 1'b0;
        clear_inputs();
        tick();
        tick();
        rst_n = 1'b1;
        bus.d_mem_read    = 1'b1;
        bus.d_mem_address = 16'hD000;
        bus.i_mem_read    = 1'b1;
        bus.i_mem_address = 16'h1000;
        tick();
        repeat (10) tick();
        @(negedge clk);
        check("t6_stall10", 128'(stall_count), 128'(4'd10));
        repeat (10) tick();
        @(negedge clk);
        check("t6_stall_sat", 128'(stall_count), 128'(4'd15));
        check("t6_grant_held", 128'(bus.buf_mem_address), 128'(16'hD000));
        check("t6_state", 128'(dut.state), 128'(SERVE_D));

        // Asynchronous reset in the middle of SERVE_D
        tick();
        #1;
        rst_n = 1'b0;
        #1;
        check("t7_rd", 128'(bus.buf_mem_read), 128'(1'b0));
        check("t7_state", 128'(dut.state), 128'(IDLE));
        check("t7_stall", 128'(stall_count), 128'(4'd0));
        check("t7_dresp", 128'(bus.d_mem_resp), 128'(1'b0));
        clear_inputs();
        tick();
        rst_n = 1'b1;
        bus.buf_mem_resp = 1'b1;
        pulses = 0;
        repeat (3) begin
            @(negedge clk);
            if (bus.d_mem_resp) pulses++;
            tick();
        end
        check("t7_no_resp", 128'(pulses), 128'(0));
        @(negedge clk);
        check("t7_final_state", 128'(dut.state), 128'(IDLE));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
